// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// wb_arbiter_pkg : shared register-file bus widths and writeback grant codes
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

  localparam int c_reg_addr_w = 5;
  localparam int c_reg_data_w = 32;

  typedef struct packed {
    logic [c_reg_addr_w-1:0] rd;
    logic [c_reg_data_w-1:0] data;
  } wb_res_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_DIV  = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_res_fifo.sv
// ============================================================================
// wb_res_fifo : DEPTH-entry synchronous FIFO holding divider writeback results
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_res_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : shares the register-file write port between pipeline writeback
//              and buffered divider results, with an anti-starvation stall
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         pipe_wen_i,
  input  logic [c_reg_addr_w-1:0]      pipe_rd_addr_i,
  input  logic [c_reg_data_w-1:0]      pipe_rd_data_i,
  input  logic                         div_valid_i,
  input  logic [c_reg_addr_w-1:0]      div_rd_addr_i,
  input  logic [c_reg_data_w-1:0]      div_rd_data_i,
  output logic                         div_ready_o,
  output logic                         stall_req_o,
  output logic                         regs_wen_o,
  output logic [c_reg_addr_w-1:0]      rd_addr_o,
  output logic [c_reg_data_w-1:0]      rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] c_max_wait = AGE_W'(MAX_WAIT);

  wb_res_t                    w_push_res;
  wb_res_t                    w_head;
  wb_src_e                    w_grant;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_pipe_ok;
  logic [CNT_W-1:0]           w_count;
  logic [CNT_W-1:0]           w_count_nxt;
  logic [AGE_W-1:0]           r_age;
  logic [AGE_W-1:0]           w_age_nxt;
  logic                       w_stall_nxt;
  logic                       r_stall;
  logic                       r_wen;
  logic [c_reg_addr_w-1:0]    r_addr;
  logic [c_reg_data_w-1:0]    r_data;

  assign div_ready_o = !w_full;
  assign w_push      = div_valid_i && div_ready_o && (div_rd_addr_i != '0);
  assign w_pipe_ok   = pipe_wen_i && (pipe_rd_addr_i != '0);
  assign w_push_res  = '{rd: div_rd_addr_i, data: div_rd_data_i};

  wb_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_res_t))
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rstn),
    .i_push  (w_push),
    .i_wdata (w_push_res),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A stalled pipeline re-presents its write, so the buffer head wins outright
  always_comb begin
    w_grant = WB_SRC_NONE;
    if (r_stall && !w_empty)  w_grant = WB_SRC_DIV;
    else if (w_pipe_ok)       w_grant = WB_SRC_PIPE;
    else if (!w_empty)        w_grant = WB_SRC_DIV;
  end

  assign w_pop       = (w_grant == WB_SRC_DIV);
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_age_nxt = r_age;
    if (w_empty || w_pop)         w_age_nxt = '0;
    else if (r_age != c_max_wait) w_age_nxt = r_age + AGE_W'(1);
  end

  assign w_stall_nxt = (w_age_nxt == c_max_wait) && (w_count_nxt != '0);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_age   <= '0;
      r_stall <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_age   <= w_age_nxt;
      r_stall <= w_stall_nxt;
      r_wen   <= (w_grant != WB_SRC_NONE);
      case (w_grant)
        WB_SRC_PIPE: begin
          r_addr <= pipe_rd_addr_i;
          r_data <= pipe_rd_data_i;
        end
        WB_SRC_DIV: begin
          r_addr <= w_head.rd;
          r_data <= w_head.data;
        end
        default: ;
      endcase
    end
  end

  assign stall_req_o = r_stall;
  assign regs_wen_o  = r_wen;
  assign rd_addr_o   = r_addr;
  assign rd_data_o   = r_data;
  assign buf_count_o = w_count;

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Shares the single register-file write port between two sources. The first is the in-order pipeline writeback (the mem_wb/wb path). The second is the long-latency divider result stream. Divider results are held in a 2-entry buffer and written in idle writeback slots. An age counter raises a pipeline stall request so buffered results cannot starve. The block sits between wb and regs and replaces the direct wb-to-regs write connection.

Parameters:
DEPTH, 2, divider result buffer entries (power of two, ≥2)
MAX_WAIT, 8, cycles a buffered result may wait before stall_req_o asserts (≥1)

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  reset; asynchronous, active-high (asserted = 1)
pipe_wen_i  in  1  pipeline writeback write enable (from wb)
pipe_rd_addr_i  in  5  pipeline destination register
pipe_rd_data_i  in  32  pipeline writeback data
div_valid_i  in  1  divider result valid
div_rd_addr_i  in  5  divider destination register
div_rd_data_i  in  32  divider result
div_ready_o  out  1  buffer can accept a divider result this cycle
stall_req_o  out  1  request to the pipeline controller to freeze mem_wb
regs_wen_o  out  1  register-file write enable
rd_addr_o  out  5  register-file write address
rd_data_o  out  32  register-file write data
buf_count_o  out  2  current buffer occupancy (0..DEPTH)

Behaviour:
- Reset (rstn=1, async): buffer empty, age counter 0. All outputs are 0 except div_ready_o=1: regs_wen_o, rd_addr_o, rd_data_o, stall_req_o, buf_count_o = 0.
- Register-file outputs are registered. A write granted in cycle N appears on regs_* in cycle N+1. regs_wen_o is a one-cycle pulse per write.
- Divider handshake: a transfer occurs when div_valid_i && div_ready_o. div_ready_o = (count < DEPTH) and is driven only from state. A transfer with div_rd_addr_i == 0 is accepted but discarded (not pushed).
- Grant priority each cycle:
  1. stall_req_o=1 and buffer non-empty: pop the buffer head. pipe_wen_i is ignored; the pipeline is frozen and re-presents the same write next cycle.
  2. pipe_wen_i=1 and pipe_rd_addr_i≠0: write the pipeline data.
  3. Buffer non-empty: pop the head.
  4. Otherwise regs_wen_o=0 next cycle.
- A pipeline write with rd=0 is dropped and counts as an idle slot, so rule 3 may apply in the same cycle.
- Buffer is FIFO ordered, with circular read/write pointers that wrap modulo DEPTH.
- Push and pop in the same cycle: count is unchanged. A push is impossible at count=DEPTH because div_ready_o=0.
- A divider result accepted in cycle N can be popped in cycle N+1 at the earliest. There is no bypass from input to output.
- Age counter:
  - Clears when the buffer is empty or when the head is popped.
  - Otherwise increments, saturating at MAX_WAIT.
  - stall_req_o is registered: 1 while counter == MAX_WAIT and buffer non-empty.
  - Drops to 0 in the cycle after the stalled pop.
- WAW ordering between outstanding divider results and pipeline writes is guaranteed by issue logic. This block does not check it.
- Reset mid-operation discards buffered results. Re-issuing them is the issue logic's job.
- Widths come from the shared bus-width defines (5-bit register address, 32-bit register data).

Decomposition:
- Shared defines file: register address/data bus widths and a WB_SRC_PIPE/WB_SRC_DIV grant encoding for debug.
- One natural sub-module: wb_res_fifo. It is a parameterised DEPTH×37-bit synchronous FIFO with push/pop/count/full/empty and async active-high reset.
- Arbitration, age counter and output registers stay in wb_arbiter.

Test Plan:
- Reset asserted mid-stream with 2 buffered entries → next cycle buf_count_o=0, div_ready_o=1, regs_wen_o=0, stall_req_o=0.
- Pipe only: pipe_wen_i=1, rd=5, data=0x1234 → next cycle regs_wen_o=1, rd_addr_o=5, rd_data_o=0x1234. Pipe rd=0 → regs_wen_o=0.
- Div into idle port: div result rd=7, data=0xDEAD accepted at cycle N, pipe idle → regs_wen_o=1, rd_addr_o=7, rd_data_o=0xDEAD at N+2; buf_count_o returns to 0.
- Simultaneous: pipe writes rd=3 every cycle while div pushes rd=9, then rd=10 → div_ready_o=0 at count=2. Entries drain in order 9 then 10 once the pipe idles.
- Starvation: one buffered entry with the pipe writing continuously → stall_req_o=1 after MAX_WAIT=8 cycles. The next write is the buffered entry, the held pipe write follows on the following cycle, and stall_req_o returns to 0.
- Div result with rd=0 accepted → buf_count_o stays 0 and no regs_wen_o pulse.
